// File: rtl/multi_input_threshold_detector_pkg.sv
// Shared constants and helpers for the threshold detector.
// Holds the seven-segment font, the mode encodings and a clog2 helper.
package multi_input_threshold_detector_pkg;

  localparam logic MODE_ATLEAST = 1'b0;
  localparam logic MODE_EXACT   = 1'b1;

  // Active-high {g,f,e,d,c,b,a} hex font for digits 0-F
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/multi_input_threshold_detector_bit_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// The debounced bit only follows sync after DEBOUNCE_CYCLES steady cycles.
module bit_debouncer
  import multi_input_threshold_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic deb
);

  localparam int CW =
    (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser for the asynchronous switch input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else if (ena) begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Count consecutive disagreeing cycles; commit once the run is long enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (ena) begin
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_input_threshold_detector.sv
// Debounced N-input ones-count threshold detector with event counter.
// The low nibble of the saturating event count drives a hex display.
module multi_input_threshold_detector
  import multi_input_threshold_detector_pkg::*;
#(
  parameter int N_INPUTS        = 3,
  parameter int THRESH          = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ena,
  input  logic [N_INPUTS-1:0]              in_bits,
  input  logic                             mode,
  input  logic                             clr,
  output logic                             detect,
  output logic [clog2(N_INPUTS+1)-1:0]     ones_count,
  output logic [CNT_W-1:0]                 event_count,
  output logic [6:0]                       seg
);

  localparam int OW = clog2(N_INPUTS + 1);
  localparam logic [OW-1:0]    THR     = OW'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_INPUTS-1:0] deb;
  logic [OW-1:0]       pop;
  logic                det_next;
  logic [CNT_W-1:0]    cnt_next;
  logic [3:0]          nib;

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_deb
    bit_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .raw(in_bits[i]),
      .deb(deb[i])
    );
  end

  // Popcount of the debounced inputs and the threshold comparison
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      pop = pop + OW'(deb[i]);
    end
    det_next = (mode == MODE_EXACT) ? (pop == THR) : (pop >= THR);
  end

  // Next event count: clear wins, otherwise count rising detects, saturating
  always_comb begin
    cnt_next = event_count;
    if (clr) begin
      cnt_next = '0;
    end else if (det_next && !detect && (event_count != CNT_MAX)) begin
      cnt_next = event_count + 1'b1;
    end
    nib = 4'(cnt_next);
  end

  // Output registers; seg tracks the same next count as event_count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      detect      <= 1'b0;
      ones_count  <= '0;
      event_count <= '0;
      seg         <= SEG_FONT[0];
    end else if (ena) begin
      detect      <= det_next;
      ones_count  <= pop;
      event_count <= cnt_next;
      seg         <= SEG_FONT[nib];
    end
  end

endmodule

// File: tb/tb_multi_input_threshold_detector.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against two DUT instances.
module tb_multi_input_threshold_detector;

  typedef struct {
    int         at;
    bit         which;
    bit         det;
    int         ones;
    int         ev;
    logic [6:0] seg;
    bit [95:0]  name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [2:0] in1, in4;
  logic       mode1, mode4;
  logic       clr1, clr4;
  logic       det1, det4;
  logic [1:0] ones1, ones4;
  logic [7:0] ev1, ev4;
  logic [6:0] seg1, seg4;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  localparam bit [7:0] MAJ_DET = 8'b1110_1000;
  localparam int MAJ_ONES [8] = '{0, 1, 1, 2, 1, 2, 2, 3};
  localparam int MAJ_EV [8]   = '{0, 0, 0, 1, 1, 2, 2, 2};
  localparam logic [6:0] MAJ_SEG [8] = '{
    7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h06, 7'h5B, 7'h5B, 7'h5B
  };

  multi_input_threshold_detector #(
    .N_INPUTS(3), .THRESH(2), .DEBOUNCE_CYCLES(1), .CNT_W(8)
  ) u1 (
    .clk(clk), .rst(rst), .ena(ena), .in_bits(in1),
    .mode(mode1), .clr(clr1), .detect(det1),
    .ones_count(ones1), .event_count(ev1), .seg(seg1)
  );

  multi_input_threshold_detector #(
    .N_INPUTS(3), .THRESH(2), .DEBOUNCE_CYCLES(4), .CNT_W(8)
  ) u4 (
    .clk(clk), .rst(rst), .ena(ena), .in_bits(in4),
    .mode(mode4), .clr(clr4), .detect(det4),
    .ones_count(ones4), .event_count(ev4), .seg(seg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int at, input bit which, input bit d,
                           input int o, input int ev,
                           input logic [6:0] sg, input bit [95:0] nm);
    exp_t e;
    int   pos;
    e.at = at; e.which = which; e.det = d; e.ones = o;
    e.ev = ev; e.seg = sg; e.name = nm;
    pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].at > at) begin
        pos = i;
        break;
      end
    end
    q.insert(pos, e);
  endtask

  // Monitor: compare every expectation due on this cycle
  always @(negedge clk) begin
    exp_t e;
    bit   gd;
    int   go, ge;
    logic [6:0] gs;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      checks++;
      gd = e.which ? det4 : det1;
      go = e.which ? int'(ones4) : int'(ones1);
      ge = e.which ? int'(ev4) : int'(ev1);
      gs = e.which ? seg4 : seg1;
      if (e.at != cyc) begin
        errors++;
        $display("FAIL %0s: check due at cycle %0d seen at %0d",
                 e.name, e.at, cyc);
      end else if (gd !== e.det || go != e.ones ||
                   ge != e.ev || gs !== e.seg) begin
        errors++;
        $display("FAIL %0s cyc %0d: got det=%0d ones=%0d ev=%0d seg=%h want det=%0d ones=%0d ev=%0d seg=%h",
                 e.name, cyc, gd, go, ge, gs,
                 e.det, e.ones, e.ev, e.seg);
      end
    end
  end

  initial begin
    int k, m;
    bit pd;
    int po, pe;
    logic [6:0] ps;

    rst = 1'b1; ena = 1'b1;
    in1 = '0; in4 = '0;
    mode1 = 1'b0; mode4 = 1'b0;
    clr1 = 1'b0; clr4 = 1'b0;

    step(1);
    expect_at(cyc, 0, 0, 0, 0, 7'h3F, "rst1");
    expect_at(cyc, 1, 0, 0, 0, 7'h3F, "rst4");
    step(1);
    rst = 1'b0;
    step(2);

    // Majority equivalence on the single-cycle debounce instance
    pd = 0; po = 0; pe = 0; ps = 7'h3F;
    for (int p = 0; p < 8; p++) begin
      step(1);
      k = cyc;
      in1 = 3'(p);
      expect_at(k + 3, 0, pd, po, pe, ps, "maj_hold");
      expect_at(k + 4, 0, MAJ_DET[p], MAJ_ONES[p],
                MAJ_EV[p], MAJ_SEG[p], "maj_new");
      pd = MAJ_DET[p]; po = MAJ_ONES[p];
      pe = MAJ_EV[p];  ps = MAJ_SEG[p];
      step(9);
    end

    // Glitch of three cycles is rejected
    step(1);
    k = cyc;
    in4 = 3'b011;
    step(3);
    in4 = 3'b000;
    expect_at(k + 8, 1, 0, 0, 0, 7'h3F, "glitch_a");
    expect_at(k + 12, 1, 0, 0, 0, 7'h3F, "glitch_b");
    step(10);

    // Stable input: detect appears exactly at the 7th edge after drive
    step(1);
    k = cyc;
    in4 = 3'b011;
    expect_at(k + 6, 1, 0, 0, 0, 7'h3F, "deb_early");
    expect_at(k + 7, 1, 1, 2, 1, 7'h06, "deb_lat");
    step(9);

    // Exact mode
    step(1);
    k = cyc;
    in4 = 3'b111;
    mode4 = 1'b1;
    expect_at(k + 1, 1, 1, 2, 1, 7'h06, "ex_mode");
    expect_at(k + 7, 1, 0, 3, 1, 7'h06, "ex_111");
    step(9);
    step(1);
    k = cyc;
    in4 = 3'b011;
    expect_at(k + 6, 1, 0, 3, 1, 7'h06, "ex_pre");
    expect_at(k + 7, 1, 1, 2, 2, 7'h5B, "ex_011");
    step(9);
    step(1);
    k = cyc;
    in4 = 3'b111;
    expect_at(k + 7, 1, 0, 3, 2, 7'h5B, "ex_back");
    step(9);
    step(1);
    k = cyc;
    mode4 = 1'b0;
    expect_at(k, 1, 0, 3, 2, 7'h5B, "atl_pre");
    expect_at(k + 1, 1, 1, 3, 3, 7'h4F, "atl_mode");
    step(3);

    // Saturation and hex font
    step(1);
    in4 = 3'b000;
    step(9);
    for (int i = 0; i < 300; i++) begin
      step(1);
      k = cyc;
      in4 = 3'b011;
      case (i)
        0:   expect_at(k + 7, 1, 1, 2, 4, 7'h66, "sat_4");
        11:  expect_at(k + 7, 1, 1, 2, 15, 7'h71, "sat_15");
        12:  expect_at(k + 7, 1, 1, 2, 16, 7'h3F, "sat_16");
        250: expect_at(k + 7, 1, 1, 2, 254, 7'h79, "sat_254");
        251: expect_at(k + 7, 1, 1, 2, 255, 7'h71, "sat_255");
        299: expect_at(k + 7, 1, 1, 2, 255, 7'h71, "sat_hold");
        default: ;
      endcase
      step(8);
      in4 = 3'b000;
      step(9);
    end
    expect_at(cyc, 1, 0, 0, 255, 7'h71, "sat_end");

    // Clear pulse
    step(1);
    k = cyc;
    clr4 = 1'b1;
    expect_at(k, 1, 0, 0, 255, 7'h71, "clr_pre");
    step(1);
    clr4 = 1'b0;
    expect_at(cyc, 1, 0, 0, 0, 7'h3F, "clr");
    step(3);

    // Clear collides with rising detect
    step(1);
    k = cyc;
    in4 = 3'b011;
    step(6);
    clr4 = 1'b1;
    step(1);
    clr4 = 1'b0;
    expect_at(k + 7, 1, 1, 2, 0, 7'h3F, "collide");
    expect_at(k + 8, 1, 1, 2, 0, 7'h3F, "collide_hold");
    step(3);

    // Enable low freezes everything
    step(1);
    k = cyc;
    ena = 1'b0;
    in4 = 3'b000;
    expect_at(k + 10, 1, 1, 2, 0, 7'h3F, "ena_hold");
    step(10);
    ena = 1'b1;
    m = cyc;
    expect_at(m + 6, 1, 1, 2, 0, 7'h3F, "ena_pre");
    expect_at(m + 7, 1, 0, 0, 0, 7'h3F, "ena_resume");
    step(9);

    // Enable low mid-debounce keeps the partial count
    step(1);
    k = cyc;
    in4 = 3'b011;
    step(4);
    ena = 1'b0;
    step(5);
    ena = 1'b1;
    expect_at(k + 11, 1, 0, 0, 0, 7'h3F, "hold_pre");
    expect_at(k + 12, 1, 1, 2, 1, 7'h06, "hold_resume");
    step(4);

    // Asynchronous reset mid-debounce
    step(1);
    in4 = 3'b000;
    step(9);
    step(1);
    k = cyc;
    in4 = 3'b011;
    step(4);
    #2;
    rst = 1'b1;
    expect_at(k + 4, 1, 0, 0, 0, 7'h3F, "async_rst");
    step(1);
    rst = 1'b0;
    expect_at(k + 5, 1, 0, 0, 0, 7'h3F, "rst_hold");
    expect_at(k + 11, 1, 0, 0, 0, 7'h3F, "rst_pre");
    expect_at(k + 12, 1, 1, 2, 1, 7'h06, "rst_relat");
    step(8);

    for (int w = 0; w < 50; w++) begin
      if (q.size() == 0) break;
      step(1);
    end
    if (q.size() != 0) begin
      $display("FAIL drain: %0d checks never reached", q.size());
      errors += q.size();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_input_threshold_detector.md
Name: multi_input_threshold_detector

Overview:
- Parametrised, clocked successor to the team's 3-input pair/triple (majority) detector.
- Synchronises and debounces N switch inputs, then counts how many are high.
- Flags a match against a programmable threshold, in either at-least or exact mode.
- Counts detection events and drives the low nibble of that count onto a seven-segment display.

Parameters:
- N_INPUTS, 3, number of switch inputs; legal range 2..8.
- THRESH, 2, ones-count compared against; legal range 1..N_INPUTS.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before a debounced bit changes; must be >= 1.
- CNT_W, 8, event counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  design enable; when low, all state holds.
- in_bits  in  N_INPUTS  raw, asynchronous switch inputs.
- mode  in  1  0 = detect when ones >= THRESH; 1 = detect when ones == THRESH.
- clr  in  1  synchronous clear of event_count.
- detect  out  1  registered match flag.
- ones_count  out  clog2(N_INPUTS+1)  registered popcount of the debounced inputs.
- event_count  out  CNT_W  number of detect rising edges, saturating.
- seg  out  7  active-high segments {g,f,e,d,c,b,a} showing the hex value of event_count[3:0].

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. When rst=1, every flop clears immediately:
  - sync flops 0, debounced bits 0, debounce counters 0;
  - detect 0, ones_count 0, event_count 0;
  - seg = 7'h3F (digit 0).
- All other state updates on the clk rising edge, and only when ena=1. With ena=0 everything holds, including partially advanced debounce counters.
- Synchroniser: two flops per bit. Call the second-stage output sync.
- Debounce, per bit, on each enabled edge:
  - if sync == deb: cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1: deb <= sync, cnt <= 0;
  - else cnt <= cnt+1.
  - A pulse on sync shorter than DEBOUNCE_CYCLES cycles never reaches deb.
- Latency: a change first sampled at edge e0 appears on deb after edge e(DEBOUNCE_CYCLES+1), and on detect/ones_count after edge e(DEBOUNCE_CYCLES+2). With DEBOUNCE_CYCLES=4, detect updates at e6.
- ones_count <= popcount(deb). This is pure arithmetic with no overflow, because its width holds N_INPUTS.
- detect <= (mode ? popcount(deb)==THRESH : popcount(deb)>=THRESH). ones_count and detect are computed from the same deb value.
- Changing mode takes effect at the next enabled edge with no debounce. detect may therefore toggle directly on a mode change.
- event_count, on an edge where next-detect=1 and current detect=0:
  - increments, except that it holds at 2^CNT_W-1 (saturates, never wraps).
- clr=1 forces event_count <= 0 and has priority over a simultaneous rising detect; that event is lost.
- clr does not affect detect, ones_count or the debounce state.
- seg is registered from the next value of event_count[3:0] using the hex font 0-F, so it is cycle-aligned with event_count.
- Reset asserted mid-debounce discards the pending change. After release, a still-different input needs the full DEBOUNCE_CYCLES again.

Decomposition:
- Shared package:
  - SEG_FONT constant array (16 x 7 bits: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71);
  - clog2 function;
  - MODE_ATLEAST=0 / MODE_EXACT=1 constants.
- Sub-module bit_debouncer (sync pair + counter + deb flop, parameter DEBOUNCE_CYCLES), instantiated N_INPUTS times by generate.
- Top level holds the popcount, compare, edge detect, counter and seg register.

Test Plan:
- Majority equivalence: N=3, THRESH=2, DEBOUNCE_CYCLES=1, mode=0. Apply all 8 patterns, each held 10 cycles.
  - Expect detect=1 exactly for 011,101,110,111.
  - Expect ones_count = the popcount, with detect changing 3 edges after the pattern change.
- Glitch rejection: defaults. in_bits 000 -> 011 for 3 cycles -> 000.
  - Expect detect stays 0 and event_count stays 0.
  - Holding 011 for 4+ cycles gives detect=1 at edge e6 and event_count=1, seg=06.
- Exact mode: mode=1, in_bits=111 stable.
  - Expect ones_count=3, detect=0.
  - Switch to 011: detect=1 and event_count increments.
  - Switch mode to 0 while holding 111: detect=1 next edge.
- Saturation and hex display: toggle the input between 000 and 011 300 times.
  - Expect event_count stops at 255, seg=71 (F).
  - Pulse clr: event_count=0, seg=3F.
- clr collision: assert clr on the same edge as detect's 0->1 transition.
  - Expect event_count=0 and detect=1.
- Async reset and enable:
  - With ena=0, input changes do not change any output.
  - Assert rst asynchronously mid-debounce, between edges: all outputs clear before the next edge.
  - After release, latency restarts at the full DEBOUNCE_CYCLES+2.
